wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the two writeback streams leaving the MEM/WB stage of the dual-issue pipe.
- Preserves program order: inst1 is older than inst2 in the same cycle, and queued writes are older than new arrivals.
- Buffers surplus writes in a small FIFO and stalls upstream when the FIFO nears full.
- Provides a forwarding lookup so decode can see register values that are not yet committed.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 3, register address width
- DEPTH, 4, pending-write FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous reset, active-high
- wb1_valid  in  1  inst1 writeback request (older slot)
- wb1_rd  in  ADDR_W  inst1 destination register
- wb1_data  in  DATA_W  inst1 write data
- wb2_valid  in  1  inst2 writeback request (younger slot)
- wb2_rd  in  ADDR_W  inst2 destination register
- wb2_data  in  DATA_W  inst2 write data
- rf_we  out  1  register-file write enable
- rf_wa  out  ADDR_W  register-file write address
- rf_wd  out  DATA_W  register-file write data
- stall  out  1  upstream must not present new writebacks
- fwd_addr  in  ADDR_W  forwarding lookup address
- fwd_hit  out  1  fwd_addr has an uncommitted write
- fwd_data  out  DATA_W  newest uncommitted value for fwd_addr
- count  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky error: a write was dropped

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset state: FIFO is empty and count=0. Pointers are 0 and overflow=0.
- Write port: rf_we, rf_wa and rf_wd are combinational. The write takes effect at the next rising edge, so latency is 0 cycles from a request to the write-port drive.
- Idle outputs: when rf_we=0, rf_wa=0 and rf_wd=0.
- Coalescing: if wb1_valid and wb2_valid are both set and wb1_rd==wb2_rd, wb1 is discarded. Only wb2 is treated as arriving.
- Port selection, FIFO empty (count==0):
  - Only one valid write arrives: it drives the port directly and nothing is enqueued.
  - Two non-coalesced writes arrive: wb1 drives the port and wb2 is enqueued.
- Port selection, FIFO non-empty (count>0):
  - The FIFO head drives the port and is dequeued at the edge.
  - All valid, non-coalesced arrivals are enqueued in order, wb1 first then wb2.
- Occupancy update: count_next = count - deq + enq. Per cycle deq is 0 or 1 and enq is 0, 1 or 2.
- Stall:
  - stall = (count >= DEPTH-1). It is combinational from the registered count.
  - Upstream holds wb*_valid low in any cycle where stall=1.
- Overflow:
  - If enqueues would exceed DEPTH, the excess entries are dropped. wb2 is dropped before wb1.
  - overflow is set on the next edge and stays set until reset. The count saturates at DEPTH.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full is count==DEPTH and empty is count==0. There is no other state.
- Forwarding (combinational) priority order, stopping at the first match:
  1. wb2 if valid
  2. wb1 if valid and not coalesced
  3. FIFO entries, youngest to oldest
- Forwarding miss: fwd_hit=0 and fwd_data=0.
- Register 0 has no special handling; it is written like any other register.
- Reset mid-operation: pending FIFO writes are lost, and rf_we drops immediately because the FIFO is empty.

Test Plan:
- Reset, then wb1 only, rd=3, data=0xAAAA0001 -> rf_we=1, rf_wa=3, rf_wd=0xAAAA0001 in the same cycle; count stays 0.
- Dual issue, rd=1 with 0x11 and rd=2 with 0x22, FIFO empty:
  - Cycle 0: port writes r1=0x11; count becomes 1.
  - Cycle 1, no new input: port writes r2=0x22; count returns to 0.
- Dual issue with the same rd=5 (0x10 then 0x20) -> a single write r5=0x20; count stays 0; fwd_addr=5 gives hit with 0x20 in that cycle.
- Back-to-back dual issue with DEPTH=4 -> count goes 1, 2, 3; stall=1 when count=3; upstream idles and the queue drains one entry per cycle in order.
- Upstream ignores stall at count=3 and sends two writes -> one entry is accepted and the wb2 write is dropped; overflow=1 and remains set until reset.
- Assert reset while count=2 -> count=0, rf_we=0, stall=0 and overflow=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Merges the two MEM/WB writeback streams onto one register-file write port,
// keeping program order through a small pending-write FIFO with forwarding.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb1_valid,
  input  logic [ADDR_W-1:0]        wb1_rd,
  input  logic [DATA_W-1:0]        wb1_data,
  input  logic                     wb2_valid,
  input  logic [ADDR_W-1:0]        wb2_rd,
  input  logic [DATA_W-1:0]        wb2_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_wa,
  output logic [DATA_W-1:0]        rf_wd,
  output logic                     stall,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rptr, wptr;

  logic              coalesce, a1, a2, deq, drop;
  logic [CW-1:0]     n_req, n_acc, free;
  logic [ADDR_W-1:0] req0_rd, req1_rd;
  logic [DATA_W-1:0] req0_data, req1_data;

  // Port select and enqueue list: arrivals are listed oldest first, and any
  // surplus beyond free space is cut from the young end.
  always_comb begin
    coalesce  = wb1_valid && wb2_valid && (wb1_rd == wb2_rd);
    a1        = wb1_valid && !coalesce;
    a2        = wb2_valid;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    deq       = 1'b0;
    n_req     = '0;
    req0_rd   = '0;
    req0_data = '0;
    req1_rd   = '0;
    req1_data = '0;
    if (count == '0) begin
      if (a1) begin
        rf_we = 1'b1;
        rf_wa = wb1_rd;
        rf_wd = wb1_data;
        if (a2) begin
          req0_rd   = wb2_rd;
          req0_data = wb2_data;
          n_req     = CW'(1);
        end
      end else if (a2) begin
        rf_we = 1'b1;
        rf_wa = wb2_rd;
        rf_wd = wb2_data;
      end
    end else begin
      rf_we = 1'b1;
      rf_wa = mem_rd[rptr];
      rf_wd = mem_data[rptr];
      deq   = 1'b1;
      if (a1 && a2) begin
        req0_rd   = wb1_rd;
        req0_data = wb1_data;
        req1_rd   = wb2_rd;
        req1_data = wb2_data;
        n_req     = CW'(2);
      end else if (a1) begin
        req0_rd   = wb1_rd;
        req0_data = wb1_data;
        n_req     = CW'(1);
      end else if (a2) begin
        req0_rd   = wb2_rd;
        req0_data = wb2_data;
        n_req     = CW'(1);
      end
    end
    // The slot freed by this cycle's dequeue is not reusable until next cycle.
    free  = CW'(DEPTH) - count;
    drop  = (n_req > free);
    n_acc = drop ? free : n_req;
  end

  assign stall = (count >= CW'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (deq) rptr <= rptr + PW'(1);
      wptr  <= wptr + n_acc[PW-1:0];
      count <= count - CW'(deq) + n_acc;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_acc >= CW'(1)) begin
      mem_rd[wptr]   <= req0_rd;
      mem_data[wptr] <= req0_data;
    end
    if (n_acc == CW'(2)) begin
      mem_rd[wptr + PW'(1)]   <= req1_rd;
      mem_data[wptr + PW'(1)] <= req1_data;
    end
  end

  // Later matches override earlier ones: FIFO oldest to youngest, then wb1, then wb2.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if ((CW'(i) < count) && (mem_rd[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_data[idx];
      end
    end
    if (a1 && (wb1_rd == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wb1_data;
    end
    if (a2 && (wb2_rd == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wb2_data;
    end
  end
endmodule
